// File: rtl/pcs_pkg.sv
// Shared 1000BASE-X PCS definitions: sync FSM states, comma/idle constants and
// the 5b/6b and 3b/4b running-disparity validity tables.
package pcs_pkg;

  typedef enum logic [3:0] {
    LOSS_OF_SYNC, COMMA_DETECT_1, COMMA_DETECT_2, COMMA_DETECT_3,
    ACQUIRE_SYNC_1, ACQUIRE_SYNC_2,
    SYNC_ACQUIRED_1, SYNC_ACQUIRED_2, SYNC_ACQUIRED_2A, SYNC_ACQUIRED_3,
    SYNC_ACQUIRED_3A, SYNC_ACQUIRED_4, SYNC_ACQUIRED_4A
  } sync_state_e;

  localparam logic [6:0] COMMA_POS = 7'b0011111;
  localparam logic [6:0] COMMA_NEG = 7'b1100000;
  localparam logic [9:0] K28_5_RDN = 10'b0011111010;
  localparam logic [9:0] K28_5_RDP = 10'b1100000101;
  localparam logic [9:0] D16_2_RDN = 10'b0110110101;
  localparam logic [9:0] D16_2_RDP = 10'b1001000101;

  // {legal in rd- column, legal in rd+ column} for abcdei
  function automatic logic [1:0] cols6(input logic [5:0] s);
    case (s)
      6'b110001, 6'b101001, 6'b011001, 6'b100101, 6'b010101, 6'b110100,
      6'b001101, 6'b101100, 6'b011100, 6'b100011, 6'b010011, 6'b110010,
      6'b001011, 6'b101010, 6'b011010, 6'b100110, 6'b010110, 6'b001110:
        return 2'b11;
      6'b100111, 6'b011101, 6'b101101, 6'b110101, 6'b111000, 6'b111001,
      6'b010111, 6'b011011, 6'b111010, 6'b110011, 6'b110110, 6'b101110,
      6'b011110, 6'b101011, 6'b001111:
        return 2'b10;
      6'b011000, 6'b100010, 6'b010010, 6'b001010, 6'b000111, 6'b000110,
      6'b101000, 6'b100100, 6'b000101, 6'b001100, 6'b001001, 6'b010001,
      6'b100001, 6'b010100, 6'b110000:
        return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  // {legal in rd- column, legal in rd+ column} for fghj
  function automatic logic [1:0] cols4(input logic [3:0] s);
    case (s)
      4'b1001, 4'b0101, 4'b1010, 4'b0110:          return 2'b11;
      4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b0111: return 2'b10;
      4'b0100, 4'b0011, 4'b0010, 4'b0001, 4'b1000: return 2'b01;
      default:                                     return 2'b00;
    endcase
  endfunction

  // rd encoding: 1 = positive
  function automatic logic rd6(input logic rd, input logic [5:0] s);
    if ($countones(s) > 3 || s == 6'b000111) return 1'b1;
    if ($countones(s) < 3 || s == 6'b111000) return 1'b0;
    return rd;
  endfunction

  function automatic logic rd4(input logic rd, input logic [3:0] s);
    if ($countones(s) > 2 || s == 4'b0011) return 1'b1;
    if ($countones(s) < 2 || s == 4'b1100) return 1'b0;
    return rd;
  endfunction

  function automatic logic cg_valid(input logic rd, input logic [9:0] cg);
    logic       mid, ok6, ok4, run_ei, k28, k_alt, a7, p7;
    logic [1:0] c6, c4;
    c6     = cols6(cg[9:4]);
    mid    = rd6(rd, cg[9:4]);
    c4     = cols4(cg[3:0]);
    ok6    = rd  ? c6[0] : c6[1];
    ok4    = mid ? c4[0] : c4[1];
    // A7 replaces P7 only where P7 would create a run of five
    run_ei = mid ? (cg[5:4] == 2'b00) : (cg[5:4] == 2'b11);
    k28    = cg[9:4] inside {6'b001111, 6'b110000};
    k_alt  = k28 || (cg[9:4] inside {6'b111010, 6'b110110, 6'b101110, 6'b011110,
                                     6'b000101, 6'b001001, 6'b010001, 6'b100001});
    a7     = mid ? (cg[3:0] == 4'b1000) : (cg[3:0] == 4'b0111);
    p7     = mid ? (cg[3:0] == 4'b0001) : (cg[3:0] == 4'b1110);
    return ok6 && ok4 && !(a7 && !(run_ei || k_alt)) && !(p7 && (run_ei || k28));
  endfunction

  function automatic logic is_sa(input sync_state_e s);
    return s inside {SYNC_ACQUIRED_1, SYNC_ACQUIRED_2, SYNC_ACQUIRED_2A,
                     SYNC_ACQUIRED_3, SYNC_ACQUIRED_3A, SYNC_ACQUIRED_4,
                     SYNC_ACQUIRED_4A};
  endfunction

endpackage

// File: rtl/cg_check.sv
// Code-group classifier: comma / validity against the running disparity,
// plus the running-disparity register itself.
module cg_check
  import pcs_pkg::*;
(
  input  logic       rx_clk,
  input  logic       mr_main_reset,
  input  logic [9:0] code_group,
  input  logic       any_rd,
  output logic       comma,
  output logic       valid
);

  logic rd, ok_cur, ok_alt, rd_eff;

  assign comma  = (code_group[9:3] == COMMA_POS) || (code_group[9:3] == COMMA_NEG);
  assign ok_cur = cg_valid(rd, code_group);
  assign ok_alt = cg_valid(!rd, code_group);
  // Without sync the column is unknown: adopt whichever one the group fits
  assign rd_eff = (any_rd && !ok_cur && ok_alt) ? !rd : rd;
  assign valid  = ok_cur || (any_rd && ok_alt);

  always_ff @(posedge rx_clk or negedge mr_main_reset) begin
    if (!mr_main_reset) rd <= 1'b0;
    else                rd <= rd4(rd6(rd_eff, code_group[9:4]), code_group[3:0]);
  end

endmodule

// File: rtl/synchronization.sv
// 1000BASE-X receive synchronization FSM: finds comma alignment, tracks
// rx_even and reports sync_status, with registered sudi/sync_status outputs.
module synchronization
  import pcs_pkg::*;
(
  input  logic        rx_clk,
  input  logic        mr_main_reset,
  input  logic [9:0]  code_group,
  input  logic        signal_detect,
  output logic [10:0] sudi,
  output logic        sync_status
);

  sync_state_e state, nxt;
  logic        rx_even, rx_even_nxt;
  logic [1:0]  good_cgs;
  logic        comma, valid, cgbad, is_d, gcs_full;

  cg_check u_chk (
    .rx_clk        (rx_clk),
    .mr_main_reset (mr_main_reset),
    .code_group    (code_group),
    .any_rd        (state == LOSS_OF_SYNC),
    .comma         (comma),
    .valid         (valid)
  );

  assign cgbad    = !valid || (comma && rx_even);
  assign is_d     = valid && !comma;
  assign gcs_full = (good_cgs == 2'd3);

  always_comb begin
    nxt = state;
    case (state)
      LOSS_OF_SYNC:     nxt = comma ? COMMA_DETECT_1 : LOSS_OF_SYNC;
      COMMA_DETECT_1:   nxt = is_d ? ACQUIRE_SYNC_1  : LOSS_OF_SYNC;
      COMMA_DETECT_2:   nxt = is_d ? ACQUIRE_SYNC_2  : LOSS_OF_SYNC;
      COMMA_DETECT_3:   nxt = is_d ? SYNC_ACQUIRED_1 : LOSS_OF_SYNC;
      ACQUIRE_SYNC_1:   nxt = cgbad ? LOSS_OF_SYNC :
                              (comma && !rx_even) ? COMMA_DETECT_2 : ACQUIRE_SYNC_1;
      ACQUIRE_SYNC_2:   nxt = cgbad ? LOSS_OF_SYNC :
                              (comma && !rx_even) ? COMMA_DETECT_3 : ACQUIRE_SYNC_2;
      SYNC_ACQUIRED_1:  nxt = cgbad ? SYNC_ACQUIRED_2 : SYNC_ACQUIRED_1;
      SYNC_ACQUIRED_2:  nxt = cgbad ? SYNC_ACQUIRED_3 : SYNC_ACQUIRED_2A;
      SYNC_ACQUIRED_3:  nxt = cgbad ? SYNC_ACQUIRED_4 : SYNC_ACQUIRED_3A;
      SYNC_ACQUIRED_4:  nxt = cgbad ? LOSS_OF_SYNC    : SYNC_ACQUIRED_4A;
      SYNC_ACQUIRED_2A: nxt = cgbad ? SYNC_ACQUIRED_3 :
                              gcs_full ? SYNC_ACQUIRED_1 : SYNC_ACQUIRED_2A;
      SYNC_ACQUIRED_3A: nxt = cgbad ? SYNC_ACQUIRED_4 :
                              gcs_full ? SYNC_ACQUIRED_2 : SYNC_ACQUIRED_3A;
      SYNC_ACQUIRED_4A: nxt = cgbad ? LOSS_OF_SYNC :
                              gcs_full ? SYNC_ACQUIRED_3 : SYNC_ACQUIRED_4A;
      default:          nxt = LOSS_OF_SYNC;
    endcase
    if (!signal_detect) nxt = LOSS_OF_SYNC;
    // Entry actions are keyed on the state being entered (self-loops included)
    rx_even_nxt = (nxt inside {COMMA_DETECT_1, COMMA_DETECT_2, COMMA_DETECT_3})
                  ? 1'b1 : !rx_even;
  end

  always_ff @(posedge rx_clk or negedge mr_main_reset) begin
    if (!mr_main_reset) begin
      state       <= LOSS_OF_SYNC;
      rx_even     <= 1'b0;
      good_cgs    <= 2'd0;
      sudi        <= '0;
      sync_status <= 1'b0;
    end else begin
      state       <= nxt;
      rx_even     <= rx_even_nxt;
      sudi        <= {rx_even_nxt, code_group};
      sync_status <= is_sa(nxt);
      case (nxt)
        SYNC_ACQUIRED_2, SYNC_ACQUIRED_3, SYNC_ACQUIRED_4:
          good_cgs <= 2'd0;
        SYNC_ACQUIRED_2A, SYNC_ACQUIRED_3A, SYNC_ACQUIRED_4A:
          good_cgs <= gcs_full ? good_cgs : good_cgs + 2'd1;
        default: ;
      endcase
    end
  end

endmodule
